// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC and the canonical NOP.
package if_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_FULL  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register: load-enabled, asynchronously reset to RESET_PC.
module if_fetch_stage_pc_reg #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_PC;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry instruction buffer,
// stall hold and execute-stage redirect with discard of stale responses.
module if_fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(if_fetch_stage_pkg::RESET_PC)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             stall_i,
   input  logic                             redirect_i,
   input  logic [WIDTH-1:0]                 redirect_pc_i,
   output logic                             imem_req_o,
   output logic [WIDTH-1:0]                 imem_addr_o,
   input  logic                             imem_ready_i,
   input  logic                             imem_rvalid_i,
   input  logic [WIDTH-1:0]                 imem_rdata_i,
   output logic [WIDTH-1:0]                 instr_o,
   output logic [WIDTH-1:0]                 pc_plus4_o,
   output logic                             instr_valid_o,
   output logic                             fetch_busy_o,
   output if_fetch_stage_pkg::fetch_state_t state_o,
   output logic                             proto_err_o
);

   import if_fetch_stage_pkg::*;

   // Handshake: a request transfers on a clock edge where imem_req_o && imem_ready_i;
   // exactly one response (imem_rvalid_i high for one cycle) follows each transfer,
   // and imem_addr_o is only meaningful while imem_req_o is high.

   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] instr_q, pc_plus4_q;
   logic             pc_en, req_q, valid_q, proto_err_q;
   logic             outstanding, capture, consume;

   if_fetch_stage_pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk (clk_i),
      .rst (reset_i),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc_q)
   );

   // A response is still owed to us if one was accepted and has not yet arrived.
   assign outstanding = ((state_q == S_REQ) && imem_ready_i)
                      || ((state_q == S_WAIT) && !imem_rvalid_i)
                      || ((state_q == S_DRAIN) && !imem_rvalid_i);

   assign capture = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
   assign consume = (state_q == S_FULL) && !stall_i && !redirect_i;

   assign pc_en = redirect_i || consume;
   assign pc_d  = redirect_i ? (redirect_pc_i & ~WIDTH'(3)) : (pc_q + WIDTH'(4));

   always_comb begin
      state_d = state_q;
      if (redirect_i) begin
         state_d = outstanding ? S_DRAIN : S_REQ;
      end else begin
         unique case (state_q)
            S_REQ:   if (imem_ready_i)  state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid_i) state_d = S_FULL;
            S_FULL:  if (!stall_i)      state_d = S_REQ;
            S_DRAIN: if (imem_rvalid_i) state_d = S_REQ;
            default:                    state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_REQ;
         req_q       <= 1'b1;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         pc_plus4_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= (state_d == S_REQ);
         valid_q     <= (state_d == S_FULL);
         // A response with nothing outstanding is dropped and reported for one cycle.
         proto_err_q <= imem_rvalid_i && ((state_q == S_REQ) || (state_q == S_FULL));
         if (capture) begin
            instr_q    <= imem_rdata_i;
            pc_plus4_q <= pc_q + WIDTH'(4);
         end
      end
   end

   assign imem_req_o    = req_q;
   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign pc_plus4_o    = pc_plus4_q;
   assign instr_valid_o = valid_q;
   assign fetch_busy_o  = ~valid_q;
   assign state_o       = state_q;
   assign proto_err_o   = proto_err_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Fetch stage of the 5-stage pipelined RISC-V core, directly upstream of the IF/ID pipeline register. It owns the PC register and issues one instruction-memory request at a time over a ready/valid interface, which tolerates multi-cycle memory latency. Each returned instruction is held in a one-entry buffer and presented with PC+4 and a valid flag. It honours decode-side stalls and execute-stage branch/jump redirects, discarding stale responses after a redirect.

Parameters:
WIDTH, 32, PC/instruction/data width in bits
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk_i  input  1  clock
reset_i  input  1  reset, asynchronous, active-high
stall_i  input  1  decode stage not accepting (hazard-unit StallF)
redirect_i  input  1  taken branch/jump resolved in execute (PCSrcE)
redirect_pc_i  input  WIDTH  redirect target (PCTargetE)
imem_req_o  output  1  request valid
imem_addr_o  output  WIDTH  request address (= PC)
imem_ready_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  response valid
imem_rdata_i  input  WIDTH  response instruction
instr_o  output  WIDTH  buffered instruction -> IF/ID instr input
pc_plus4_o  output  WIDTH  PC of buffered instr + 4 -> IF/ID pc_plus4 input
instr_valid_o  output  1  buffer holds a valid instruction
fetch_busy_o  output  1  = ~instr_valid_o; hazard unit flushes IF/ID when set and not stalled

Behaviour:
- Reset (async, any state, mid-transaction included): pc_q=RESET_PC, state=S_REQ, instr_o=0, pc_plus4_o=0, instr_valid_o=0. Any response in flight at reset is not tracked. Memory must also be reset.
- States: S_REQ, S_WAIT, S_FULL, S_DRAIN.
- S_REQ: imem_req_o=1, imem_addr_o=pc_q. If imem_ready_i=1, go to S_WAIT. A request may be retargeted before acceptance; the address is committed only in the ready cycle.
- S_WAIT: imem_req_o=0. If imem_rvalid_i=1: instr_q<=rdata, pc_plus4_q<=pc_q+4, valid<=1, go to S_FULL.
- S_FULL: instr_valid_o=1. If stall_i=0, the instruction is consumed: valid<=0, pc_q<=pc_q+4, go to S_REQ. If stall_i=1, hold all outputs unchanged.
- S_DRAIN: imem_req_o=0. Wait for imem_rvalid_i, discard the data, go to S_REQ.
- Redirect has priority over stall and consumption, in every state:
  - pc_q<=redirect_pc_i with bits[1:0] forced to 0.
  - valid<=0.
  - Next state is S_DRAIN if a response is outstanding: in S_WAIT without rvalid this cycle, or in S_REQ with imem_ready_i=1 this cycle.
  - Otherwise next state is S_REQ. This includes S_WAIT with rvalid in the same cycle, where the data is discarded.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, FULL) with 1-cycle memory.
- PC arithmetic is modulo 2^WIDTH; 0xFFFF_FFFC+4 wraps to 0.
- imem_rvalid_i outside S_WAIT/S_DRAIN is a protocol error: ignored and flagged by assertion.
- Outputs come from registers only, with no combinational path from imem_rdata_i to instr_o.

Decomposition:
- Shared pipeline package: fetch_state_t enum (S_REQ, S_WAIT, S_FULL, S_DRAIN) and constants RESET_PC and NOP_INSTR (32'h0000_0013, used by the bench to check bubbles).
- One sub-module, pc_reg: WIDTH-bit enable register with async reset to RESET_PC. Next-PC selection (pc+4 vs redirect) stays in the top.

Test Plan:
1. Reset, memory with 1-cycle latency, stall_i=0 -> addresses 0x0, 0x4, 0x8 issued. Each instruction appears with instr_valid_o=1 for exactly 1 cycle, pc_plus4_o=0x4, 0x8, 0xC.
2. Instruction 0x00500093 at 0x0 in S_FULL, stall_i=1 for 4 cycles -> instr_o, pc_plus4_o=0x4 and valid held. No new request until the cycle after stall_i falls.
3. Memory latency 5 cycles, redirect_i=1 to 0x40 during S_WAIT -> the late 0x0 response is discarded and the next request address is 0x40. instr_o never shows the 0x0 data after the redirect.
4. Redirect to 0x80 with stall_i=1 while in S_FULL -> buffer is invalidated, imem_addr_o=0x80 next cycle, pc_plus4_o=0x84 on return.
5. Redirect to 0x103 -> imem_addr_o=0x100. Separately, from PC 0xFFFF_FFFC: pc_plus4_o=0x0 and the next request is to 0x0.
6. Assert reset_i in S_WAIT -> all outputs reach their reset values asynchronously. After release, the first request is to RESET_PC and a stray rvalid is flagged.
